// File: rtl/logic4_pkg.sv
// Shared encodings and state type for the 4-level truth-table sequencer.
package logic4_pkg;

  // 4-level value encoding
  localparam logic [1:0] L4_0 = 2'b00;
  localparam logic [1:0] L4_1 = 2'b01;
  localparam logic [1:0] L4_X = 2'b10;
  localparam logic [1:0] L4_Z = 2'b11;

  // Operator codes
  localparam logic [1:0] OP_AND    = 2'd0;
  localparam logic [1:0] OP_XOR    = 2'd1;
  localparam logic [1:0] OP_BUFIF0 = 2'd2;
  localparam logic [1:0] OP_NOTIF1 = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EMIT,
    S_GAP,
    S_DONE
  } state_t;

  // Final row: last operand of the last operator being swept.
  function automatic logic is_last_row(input logic [1:0] op, input logic [1:0] a,
                                       input logic all_ops);
    return (a == 2'd3) && (!all_ops || op == 2'd3);
  endfunction

endpackage

// File: rtl/logic4_eval.sv
// Combinational evaluation of one operator on two 4-level operands.
// For bufif0/notif1, a is the data input and b is the control input.
module logic4_eval (
  input  logic [1:0] op,
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [1:0] y
);
  import logic4_pkg::*;

  // Operator truth tables over {0, 1, x, z}
  always_comb begin
    // NOTE: a default assignment first guarantees every path drives y, so no latch is inferred.
    y = L4_X;
    case (op)
      OP_AND: begin
        if (a == L4_0 || b == L4_0)      y = L4_0;
        else if (a == L4_1 && b == L4_1) y = L4_1;
        else                             y = L4_X;
      end
      OP_XOR: begin
        // x and z both have bit 1 set; either makes the result unknown
        if (a[1] || b[1]) y = L4_X;
        else              y = {1'b0, a[0] ^ b[0]};
      end
      OP_BUFIF0: begin
        case (b)
          L4_0:    y = (a == L4_Z) ? L4_X : a;
          L4_1:    y = L4_Z;
          default: y = L4_X;
        endcase
      end
      default: begin // OP_NOTIF1
        case (b)
          L4_1:    y = a[1] ? L4_X : {1'b0, ~a[0]};
          L4_0:    y = L4_Z;
          default: y = L4_X;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/logic4_table_sequencer.sv
// Sweeps the row operand of one or all operators and emits one packed
// truth-table row per valid/ready handshake, with optional idle gaps.
module logic4_table_sequencer #(
  parameter int ROW_GAP = 0,
  parameter int GAP_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] op_sel,
  input  logic       all_ops,
  output logic       busy,
  output logic       row_valid,
  input  logic       row_ready,
  output logic [1:0] row_op,
  output logic [1:0] row_a,
  output logic [7:0] row_data,
  output logic       row_last,
  output logic       done
);
  import logic4_pkg::*;

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [1:0]         a_q, a_d;
  logic               all_ops_q, all_ops_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               row_valid_q, row_valid_d;
  logic               row_last_q, row_last_d;
  logic [7:0]         row_data_q, row_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // One evaluator per control/second operand b = 0, 1, x, z, fed with the
  // next row's operator and operand so the row data is ready as a register.
  for (genvar gi = 0; gi < 4; gi++) begin : g_eval
    logic4_eval u_eval (
      .op (op_d),
      .a  (a_d),
      .b  (2'(gi)),
      .y  (row_data_d[2*gi +: 2])
    );
  end

  // Next-state and next-row computation
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    all_ops_d = all_ops_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_EMIT;
          op_d      = all_ops ? OP_AND : op_sel;
          all_ops_d = all_ops;
          a_d       = L4_0;
        end
      end
      S_EMIT: begin
        if (row_ready) begin
          if (row_last_q) begin
            state_d = S_DONE;
          end else begin
            a_d = a_q + 2'd1;
            if (a_q == 2'd3 && all_ops_q) op_d = op_q + 2'd1;
            gap_cnt_d = '0;
            state_d   = (ROW_GAP > 0) ? S_GAP : S_EMIT;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_EMIT;
        else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      default: state_d = S_IDLE; // S_DONE
    endcase

    row_valid_d = (state_d == S_EMIT);
    row_last_d  = row_valid_d && is_last_row(op_d, a_d, all_ops_d);
    busy_d      = (state_d == S_EMIT) || (state_d == S_GAP);
    done_d      = (state_d == S_DONE);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      a_q         <= '0;
      all_ops_q   <= 1'b0;
      gap_cnt_q   <= '0;
      row_valid_q <= 1'b0;
      row_last_q  <= 1'b0;
      row_data_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      all_ops_q   <= all_ops_d;
      gap_cnt_q   <= gap_cnt_d;
      row_valid_q <= row_valid_d;
      row_last_q  <= row_last_d;
      row_data_q  <= row_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign row_valid = row_valid_q;
  assign row_op    = op_q;
  assign row_a     = a_q;
  assign row_data  = row_data_q;
  assign row_last  = row_last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_logic4_table_sequencer.sv
// Directed bench: table of expected rows for several sweeps, plus hand-written
// backpressure, row-gap and mid-sweep reset sequences.
module tb_logic4_table_sequencer;

  logic clk;
  logic rst;
  logic [1:0] op_sel;
  logic all_ops;

  // Instance with back-to-back rows
  logic start0, row_ready0;
  logic busy0, row_valid0, row_last0, done0;
  logic [1:0] row_op0, row_a0;
  logic [7:0] row_data0;

  // Instance with a 3-cycle row gap
  logic start3, row_ready3;
  logic busy3, row_valid3, row_last3, done3;
  logic [1:0] row_op3, row_a3;
  logic [7:0] row_data3;

  int n_vec = 0;
  int n_err = 0;

  logic4_table_sequencer #(.ROW_GAP(0), .GAP_W(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .op_sel(op_sel), .all_ops(all_ops),
    .busy(busy0), .row_valid(row_valid0), .row_ready(row_ready0),
    .row_op(row_op0), .row_a(row_a0), .row_data(row_data0),
    .row_last(row_last0), .done(done0)
  );

  logic4_table_sequencer #(.ROW_GAP(3), .GAP_W(4)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .op_sel(op_sel), .all_ops(all_ops),
    .busy(busy3), .row_valid(row_valid3), .row_ready(row_ready3),
    .row_op(row_op3), .row_a(row_a3), .row_data(row_data3),
    .row_last(row_last3), .done(done3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed row_data, indexed by {op, a}
  logic [7:0] exp_data [16] = '{
    8'h00, 8'hA4, 8'hA8, 8'hA8,   // AND    a=0,1,x,z
    8'hA4, 8'hA1, 8'hAA, 8'hAA,   // XOR
    8'hAC, 8'hAD, 8'hAE, 8'hAE,   // BUFIF0
    8'hA7, 8'hA3, 8'hAB, 8'hAB    // NOTIF1
  };

  typedef struct {
    logic [1:0] op_sel;
    logic       all_ops;
    logic       first;
    logic [1:0] exp_op;
    logic [1:0] exp_a;
    logic [7:0] exp_data;
    logic       exp_last;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_sweep(input logic [1:0] op, input logic all);
    int n;
    n = all ? 16 : 4;
    for (int i = 0; i < n; i++) begin
      vec_t v;
      v.op_sel   = op;
      v.all_ops  = all;
      v.first    = (i == 0);
      v.exp_op   = all ? 2'(i / 4) : op;
      v.exp_a    = 2'(i % 4);
      v.exp_data = exp_data[{v.exp_op, v.exp_a}];
      v.exp_last = (i == n - 1);
      vecs.push_back(v);
    end
  endtask

  initial begin
    rst = 1'b1; op_sel = 2'd0; all_ops = 1'b0;
    start0 = 1'b0; row_ready0 = 1'b1;
    start3 = 1'b0; row_ready3 = 1'b1;
    step(); step();

    // Reset state
    check("rst busy", busy0, 0);
    check("rst row_valid", row_valid0, 0);
    check("rst row_last", row_last0, 0);
    check("rst done", done0, 0);
    check("rst row_op", row_op0, 0);
    check("rst row_a", row_a0, 0);
    check("rst row_data", row_data0, 0);

    // start together with rst: reset wins, start not latched
    start0 = 1'b1; op_sel = 2'd1;
    step();
    check("rst+start busy", busy0, 0);
    check("rst+start valid", row_valid0, 0);
    rst = 1'b0; start0 = 1'b0;
    step();
    check("rst+start idle", row_valid0, 0);

    // Table-driven sweeps, row_ready held high
    add_sweep(2'd0, 1'b0);
    add_sweep(2'd1, 1'b0);
    add_sweep(2'd2, 1'b0);
    add_sweep(2'd3, 1'b0);
    add_sweep(2'd2, 1'b1);
    foreach (vecs[i]) begin
      if (vecs[i].first) begin
        op_sel = vecs[i].op_sel; all_ops = vecs[i].all_ops; start0 = 1'b1;
        step();
        start0 = 1'b0;
        check($sformatf("v%0d busy", i), busy0, 1);
      end
      check($sformatf("v%0d valid", i), row_valid0, 1);
      check($sformatf("v%0d op", i), row_op0, vecs[i].exp_op);
      check($sformatf("v%0d a", i), row_a0, vecs[i].exp_a);
      check($sformatf("v%0d data", i), row_data0, vecs[i].exp_data);
      check($sformatf("v%0d last", i), row_last0, vecs[i].exp_last);
      step();
      if (vecs[i].exp_last) begin
        check($sformatf("v%0d done", i), done0, 1);
        check($sformatf("v%0d done busy", i), busy0, 0);
        check($sformatf("v%0d done valid", i), row_valid0, 0);
        step();
        check($sformatf("v%0d done pulse", i), done0, 0);
      end
    end

    // Backpressure: stall row 2 of an XOR sweep for 5 cycles
    op_sel = 2'd1; all_ops = 1'b0; row_ready0 = 1'b1; start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    step();
    check("bp row2 a", row_a0, 2);
    row_ready0 = 1'b0; op_sel = 2'd0; all_ops = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("bp%0d valid", k), row_valid0, 1);
      check($sformatf("bp%0d a", k), row_a0, 2);
      check($sformatf("bp%0d op", k), row_op0, 1);
      check($sformatf("bp%0d data", k), row_data0, 8'hAA);
      check($sformatf("bp%0d last", k), row_last0, 0);
    end
    row_ready0 = 1'b1;
    step();
    check("bp row3 a", row_a0, 3);
    check("bp row3 data", row_data0, 8'hAA);
    check("bp row3 last", row_last0, 1);
    step();
    check("bp done", done0, 1);
    step();

    // Row gap of 3 on a NOTIF1 sweep, start pulsed mid-sweep
    op_sel = 2'd3; all_ops = 1'b0; row_ready3 = 1'b1; start3 = 1'b1;
    step();
    start3 = 1'b0;
    for (int r = 0; r < 4; r++) begin
      check($sformatf("gap row%0d valid", r), row_valid3, 1);
      check($sformatf("gap row%0d a", r), row_a3, r);
      check($sformatf("gap row%0d data", r), row_data3, exp_data[12 + r]);
      check($sformatf("gap row%0d last", r), row_last3, r == 3);
      step();
      if (r < 3) begin
        for (int g = 0; g < 3; g++) begin
          check($sformatf("gap%0d.%0d valid", r, g), row_valid3, 0);
          check($sformatf("gap%0d.%0d busy", r, g), busy3, 1);
          start3 = (g == 0);
          step();
        end
        start3 = 1'b0;
      end
    end
    check("gap done", done3, 1);
    check("gap done busy", busy3, 0);
    step();
    check("gap done pulse", done3, 0);
    check("gap idle valid", row_valid3, 0);

    // Reset during the third row of an all_ops sweep
    op_sel = 2'd1; all_ops = 1'b1; row_ready0 = 1'b1; start0 = 1'b1;
    step();
    start0 = 1'b0;
    step();
    step();
    check("mid row3 a", row_a0, 2);
    check("mid row3 data", row_data0, 8'hA8);
    row_ready0 = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid rst busy", busy0, 0);
    check("mid rst valid", row_valid0, 0);
    check("mid rst last", row_last0, 0);
    check("mid rst done", done0, 0);
    check("mid rst op", row_op0, 0);
    check("mid rst a", row_a0, 0);
    check("mid rst data", row_data0, 0);
    step();
    check("mid rst no done", done0, 0);
    op_sel = 2'd3; all_ops = 1'b1; start0 = 1'b1; row_ready0 = 1'b1;
    step();
    start0 = 1'b0;
    check("restart valid", row_valid0, 1);
    check("restart op", row_op0, 0);
    check("restart a", row_a0, 0);
    check("restart data", row_data0, 8'h00);
    step();
    check("restart row2 a", row_a0, 1);
    check("restart row2 data", row_data0, 8'hA4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
